vedic_mult_pipe: RTL and testbench

Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier with a valid/ready stream interface and an optional signed mode. It generalises the fixed-width combinational Vedic multipliers to any power-of-two width. It registers operands, half-width partial products and the final sum in three stages, so it can sit in the 32-bit datapath at full clock rate with backpressure.

---
 rtl/vedic_mult_pipe.sv | 139 +++++++++++++
 tb/tb_vedic_mult_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mult_pipe.sv
// rtl/vedic_mult_pipe.sv - three-stage pipelined Vedic multiplier with valid/ready handshake
// Holds the recursive Urdhva-Tiryagbhyam helper block and the pipelined top level.

module vedic_mul #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  generate
    if (N == 2) begin : g_base
      logic x0, x1, hh, c1;
      assign x0   = a[1] & b[0];
      assign x1   = a[0] & b[1];
      assign hh   = a[1] & b[1];
      assign c1   = x0 & x1;
      assign p[0] = a[0] & b[0];
      assign p[1] = x0 ^ x1;
      assign p[2] = hh ^ c1;
      assign p[3] = hh & c1;
    end else begin : g_rec
      localparam int H = N / 2;
      logic [N-1:0]   ll, hl, lh, hh;
      logic [N:0]     mid;
      logic [N+H-1:0] upper;

      vedic_mul #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
      vedic_mul #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
      vedic_mul #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
      vedic_mul #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));

      // Low H bits of ll pass straight through; everything above comes from the adders.
      assign mid   = {1'b0, hl} + {1'b0, lh};
      assign upper = {hh, ll[N-1:H]} + {{(H-1){1'b0}}, mid};
      assign p     = {upper, ll[H-1:0]};
    end
  endgenerate
endmodule

module vedic_mult_pipe #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);
  localparam int H = WIDTH / 2;

  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  logic [WIDTH-1:0] a1, b1;
  logic             neg1;
  logic [WIDTH-1:0] pll2, phl2, plh2, phh2;
  logic             neg2;
  logic [2*WIDTH-1:0] p3;

  logic             signed_eff, neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] pll_w, phl_w, plh_w, phh_w;
  logic [WIDTH:0]     mid;
  logic [WIDTH+H-1:0] upper;
  logic [2*WIDTH-1:0] mag, prod;

  // A stage loads whenever it is empty or the stage after it is moving.
  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;
  assign out_p     = p3;

  assign signed_eff = SIGNED_EN && in_signed;
  assign neg_a      = signed_eff && in_a[WIDTH-1];
  assign neg_b      = signed_eff && in_b[WIDTH-1];
  assign abs_a      = neg_a ? -in_a : in_a;
  assign abs_b      = neg_b ? -in_b : in_b;

  vedic_mul #(.N(H)) u_pll (.a(a1[H-1:0]),     .b(b1[H-1:0]),     .p(pll_w));
  vedic_mul #(.N(H)) u_phl (.a(a1[WIDTH-1:H]), .b(b1[H-1:0]),     .p(phl_w));
  vedic_mul #(.N(H)) u_plh (.a(a1[H-1:0]),     .b(b1[WIDTH-1:H]), .p(plh_w));
  vedic_mul #(.N(H)) u_phh (.a(a1[WIDTH-1:H]), .b(b1[WIDTH-1:H]), .p(phh_w));

  always_comb begin
    mid   = {1'b0, phl2} + {1'b0, plh2};
    upper = {phh2, pll2[WIDTH-1:H]} + {{(H-1){1'b0}}, mid};
    mag   = {upper, pll2[H-1:0]};
    prod  = neg2 ? -mag : mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      neg1 <= 1'b0;
      pll2 <= '0;
      phl2 <= '0;
      plh2 <= '0;
      phh2 <= '0;
      neg2 <= 1'b0;
      p3   <= '0;
    end else begin
      if (ld1) begin
        v1 <= in_valid;
        if (in_valid) begin
          a1   <= abs_a;
          b1   <= abs_b;
          neg1 <= neg_a ^ neg_b;
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          pll2 <= pll_w;
          phl2 <= phl_w;
          plh2 <= plh_w;
          phh2 <= phh_w;
          neg2 <= neg1;
        end
      end
      if (ld3) begin
        v3 <= v2;
        if (v2) p3 <= prod;
      end
    end
  end
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb/tb_vedic_mult_pipe.sv - scoreboard bench for vedic_mult_pipe
module tb_vedic_mult_pipe;
  logic clk;
  logic rst_n;

  logic        v32, r32, s32, ir32, ov32;
  logic [31:0] a32, b32;
  logic [63:0] op32;
  logic        v4, r4, s4, ir4, ov4;
  logic [3:0]  a4, b4;
  logic [7:0]  op4;
  logic        v8, r8, s8, ir8, ov8;
  logic [7:0]  a8, b8;
  logic [15:0] op8;
  logic        v16, r16, s16, ir16, ov16;
  logic [15:0] a16, b16;
  logic [31:0] op16;

  logic [63:0] q32[$];
  logic [7:0]  q4[$];
  logic [15:0] q8[$];
  logic [31:0] q16[$];

  int checks = 0;
  int errors = 0;

  vedic_mult_pipe u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(ir32), .in_a(a32), .in_b(b32),
    .in_signed(s32), .out_valid(ov32), .out_ready(r32), .out_p(op32));
  vedic_mult_pipe #(.WIDTH(4), .SIGNED_EN(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_signed(s4), .out_valid(ov4), .out_ready(r4), .out_p(op4));
  vedic_mult_pipe #(.WIDTH(8), .SIGNED_EN(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_signed(s8), .out_valid(ov8), .out_ready(r8), .out_p(op8));
  vedic_mult_pipe #(.WIDTH(16), .SIGNED_EN(1'b0)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_signed(s16), .out_valid(ov16), .out_ready(r16), .out_p(op16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref32(logic [31:0] a, logic [31:0] b, logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Samples handshakes mid-cycle, pushes expectations on accept, pops on delivery.
  task automatic tick();
    #3;
    if (v32 && ir32) q32.push_back(ref32(a32, b32, s32));
    if (v4 && ir4)   q4.push_back({4'b0, a4} * {4'b0, b4});
    if (v8 && ir8)   q8.push_back({8'b0, a8} * {8'b0, b8});
    if (v16 && ir16) q16.push_back({16'b0, a16} * {16'b0, b16});
    if (ov32 && r32) begin
      chk("w32_expected_output", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) chk("w32_product", op32, q32.pop_front());
    end
    if (ov4 && r4) begin
      chk("w4_expected_output", 64'(q4.size() != 0), 64'd1);
      if (q4.size() != 0) chk("w4_product", 64'(op4), 64'(q4.pop_front()));
    end
    if (ov8 && r8) begin
      chk("w8_expected_output", 64'(q8.size() != 0), 64'd1);
      if (q8.size() != 0) chk("w8_product", 64'(op8), 64'(q8.pop_front()));
    end
    if (ov16 && r16) begin
      chk("w16_expected_output", 64'(q16.size() != 0), 64'd1);
      if (q16.size() != 0) chk("w16_product", 64'(op16), 64'(q16.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] hold;
    int k;
    rst_n = 1'b0;
    {v32, r32, s32, a32, b32} = '0;
    {v4, s4, a4, b4} = '0;
    {v8, s8, a8, b8} = '0;
    {v16, s16, a16, b16} = '0;
    r4 = 1'b1; r8 = 1'b1; r16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(ov32), 64'd0);
    chk("reset_out_p", op32, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(ir32), 64'd1);

    // Single op latency: accepted at edge N, valid after edge N+2.
    a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; s32 = 1'b0; v32 = 1'b1; r32 = 1'b0;
    tick();
    v32 = 1'b0;
    chk("lat_valid_n", 64'(ov32), 64'd0);
    tick();
    chk("lat_valid_n1", 64'(ov32), 64'd0);
    tick();
    chk("lat_valid_n2", 64'(ov32), 64'd1);
    chk("lat_product", op32, 64'hFFFF_FFFE_0000_0001);
    r32 = 1'b1;
    tick();
    tick();
    chk("lat_drained", 64'(ov32), 64'd0);

    // Signed corners.
    s32 = 1'b1; v32 = 1'b1;
    a32 = 32'h8000_0000; b32 = 32'h8000_0000; tick();
    a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0002; tick();
    a32 = 32'h8000_0000; b32 = 32'h0000_0001; tick();
    v32 = 1'b0;
    chk("corner_first_valid", 64'(ov32), 64'd1);
    chk("corner_first_product", op32, 64'h4000_0000_0000_0000);
    tick();
    chk("corner_second_product", op32, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    chk("corner_third_product", op32, 64'hFFFF_FFFF_8000_0000);
    tick();
    chk("corner_drained", 64'(q32.size()), 64'd0);

    // Back-to-back streaming with no bubbles.
    r32 = 1'b1; v32 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1));
      tick();
      chk("stream_in_ready", 64'(ir32), 64'd1);
      if (i >= 2) chk("stream_no_bubble", 64'(ov32), 64'd1);
    end
    v32 = 1'b0;
    repeat (3) tick();
    chk("stream_drained", 64'(q32.size()), 64'd0);

    // Backpressure: three accepts fill the pipe, then output holds.
    r32 = 1'b0; v32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1));
      tick();
    end
    chk("bp_in_ready_low", 64'(ir32), 64'd0);
    chk("bp_out_valid", 64'(ov32), 64'd1);
    hold = op32;
    for (int i = 0; i < 10; i++) begin
      a32 = $urandom; b32 = $urandom;
      tick();
      chk("bp_hold_p", op32, hold);
      chk("bp_hold_valid", 64'(ov32), 64'd1);
      chk("bp_hold_in_ready", 64'(ir32), 64'd0);
    end
    for (int i = 0; i < 300; i++) begin
      v32 = 1'($urandom_range(0, 1)); r32 = 1'($urandom_range(0, 1));
      a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1));
      tick();
    end
    v32 = 1'b0; r32 = 1'b1; k = 0;
    while (q32.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    repeat (3) tick();
    chk("bp_drained", 64'(q32.size()), 64'd0);
    chk("bp_no_extra", 64'(ov32), 64'd0);

    // Reset with three in flight.
    r32 = 1'b0; v32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a32 = $urandom; b32 = $urandom; tick();
    end
    v32 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(ov32), 64'd0);
    chk("rst_async_p", op32, 64'd0);
    q32.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_release_valid", 64'(ov32), 64'd0);
    chk("rst_release_in_ready", 64'(ir32), 64'd1);
    a32 = 32'd5; b32 = 32'd7; s32 = 1'b0; v32 = 1'b1; r32 = 1'b1;
    tick();
    v32 = 1'b0;
    tick();
    tick();
    chk("rst_new_valid", 64'(ov32), 64'd1);
    chk("rst_new_product", op32, 64'd35);
    repeat (4) tick();
    chk("rst_no_stale", 64'(q32.size()), 64'd0);

    // Unsigned-only widths: in_signed must be ignored.
    a4 = 4'hF; b4 = 4'hF; s4 = 1'b1; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    tick();
    tick();
    chk("w4_signed_ignored_valid", 64'(ov4), 64'd1);
    chk("w4_signed_ignored", 64'(op4), 64'h00E1);
    tick();
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] iv;
      iv = 16'(i);
      a8 = iv[15:8]; b8 = iv[7:0]; s8 = 1'($urandom_range(0, 1)); v8 = 1'b1;
      v4 = (i < 256); a4 = iv[7:4]; b4 = iv[3:0]; s4 = 1'($urandom_range(0, 1));
      v16 = (i < 2000); a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom_range(0, 1));
      tick();
    end
    v4 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    repeat (4) tick();
    chk("w4_drained", 64'(q4.size()), 64'd0);
    chk("w8_drained", 64'(q8.size()), 64'd0);
    chk("w16_drained", 64'(q16.size()), 64'd0);
    chk("sweep_in_ready", {61'd0, ir4, ir8, ir16}, 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
